// File: rtl/lift_pkg.sv
// Shared constants and state codes for the lift scheduler and lift controller.
package lift_pkg;

  localparam int N_FLOORS_DEF = 11;
  localparam int FLOOR_W_DEF  = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_UP   = 2'd1,
    SCHED_DOWN = 2'd2
  } sched_state_e;

  // Door and motion codes used by the lift controller on the other side.
  typedef enum logic [1:0] {
    DOOR_CLOSED  = 2'd0,
    DOOR_OPENING = 2'd1,
    DOOR_OPEN    = 2'd2,
    DOOR_CLOSING = 2'd3
  } door_state_e;

  typedef enum logic [1:0] {
    MOVE_STOP = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } move_state_e;

endpackage

// File: rtl/lift_call_scheduler_if.sv
// Call-button / controller bundle between the call scheduler and the lift controller.
interface lift_call_scheduler_if #(
  parameter int N_FLOORS = 11,
  parameter int FLOOR_W  = 4
);
  logic [N_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]  car_floor;
  logic                arrive;
  logic [FLOOR_W-1:0]  target_floor;
  logic                target_valid;
  logic                dir_up;
  logic [N_FLOORS-1:0] pending;
  logic                busy;

  modport slave (
    input  call_req, car_floor, arrive,
    output target_floor, target_valid, dir_up, pending, busy
  );

  modport master (
    output call_req, car_floor, arrive,
    input  target_floor, target_valid, dir_up, pending, busy
  );
endinterface

// File: rtl/lift_floor_search.sv
// Combinational search of the pending vector relative to the car position:
// masks floors above/below the car, then priority-encodes the nearest one.
module lift_floor_search #(
  parameter int N_FLOORS = 11,
  parameter int FLOOR_W  = 4
) (
  input  logic [N_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]  car_floor,
  output logic                any_above,
  output logic                any_below,
  output logic                any_here,
  output logic [FLOOR_W-1:0]  lowest_above,
  output logic [FLOOR_W-1:0]  highest_below
);

  logic [N_FLOORS-1:0] above, below;

  always_comb begin
    above    = '0;
    below    = '0;
    any_here = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above[i] = pending[i] && (FLOOR_W'(i) > car_floor);
      below[i] = pending[i] && (FLOOR_W'(i) < car_floor);
      if (pending[i] && (FLOOR_W'(i) == car_floor)) any_here = 1'b1;
    end
  end

  assign any_above = |above;
  assign any_below = |below;

  // Scan order makes the last hit win: downward for lowest, upward for highest.
  always_comb begin
    lowest_above  = '0;
    highest_below = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (above[i]) lowest_above = FLOOR_W'(i);
    for (int i = 0; i < N_FLOORS; i++)
      if (below[i]) highest_below = FLOOR_W'(i);
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN-policy call scheduler: latches floor calls and picks the next target
// floor in the current sweep direction, reversing when the sweep runs dry.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int N_FLOORS = N_FLOORS_DEF,
  parameter int FLOOR_W  = FLOOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  lift_call_scheduler_if.slave  bus
);

  sched_state_e        state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, clr;
  logic [FLOOR_W-1:0]  tgt_q, tgt_d, eff_floor;
  logic                vld_q, vld_d, dir_q, dir_d, busy_q;
  logic                floor_ok;
  logic                any_above, any_below, any_here;
  logic [FLOOR_W-1:0]  lowest_above, highest_below;

  // Out-of-range car positions never clear a call and search as floor 0.
  assign floor_ok  = int'(bus.car_floor) < N_FLOORS;
  assign eff_floor = floor_ok ? bus.car_floor : '0;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_FLOORS; i++)
      clr[i] = bus.arrive && floor_ok && (bus.car_floor == FLOOR_W'(i));
  end

  lift_floor_search #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_search (
    .pending       (pending_q),
    .car_floor     (eff_floor),
    .any_above     (any_above),
    .any_below     (any_below),
    .any_here      (any_here),
    .lowest_above  (lowest_above),
    .highest_below (highest_below)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    vld_d   = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      SCHED_IDLE: begin
        if (any_above) begin
          state_d = SCHED_UP;   tgt_d = lowest_above;  vld_d = 1'b1; dir_d = 1'b1;
        end else if (any_below) begin
          state_d = SCHED_DOWN; tgt_d = highest_below; vld_d = 1'b1; dir_d = 1'b0;
        end else if (any_here) begin
          tgt_d = eff_floor; vld_d = 1'b1;
        end
      end
      SCHED_UP: begin
        if (any_above) begin
          tgt_d = lowest_above; vld_d = 1'b1;
        end else if (any_below) begin
          state_d = SCHED_DOWN; tgt_d = highest_below; vld_d = 1'b1; dir_d = 1'b0;
        end else begin
          state_d = SCHED_IDLE;
          if (any_here) begin tgt_d = eff_floor; vld_d = 1'b1; end
        end
      end
      SCHED_DOWN: begin
        if (any_below) begin
          tgt_d = highest_below; vld_d = 1'b1;
        end else if (any_above) begin
          state_d = SCHED_UP; tgt_d = lowest_above; vld_d = 1'b1; dir_d = 1'b1;
        end else begin
          state_d = SCHED_IDLE;
          if (any_here) begin tgt_d = eff_floor; vld_d = 1'b1; end
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      state_q   <= SCHED_IDLE;
      tgt_q     <= '0;
      vld_q     <= 1'b0;
      dir_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      // Clear beats set: a call at the floor being served is absorbed.
      pending_q <= (pending_q | bus.call_req) & ~clr;
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      vld_q     <= vld_d;
      dir_q     <= dir_d;
      busy_q    <= (state_d != SCHED_IDLE);
    end
  end

  assign bus.pending      = pending_q;
  assign bus.target_floor = tgt_q;
  assign bus.target_valid = vld_q;
  assign bus.dir_up       = dir_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Scoreboard bench: the driver steps a rule-level SCAN model each cycle and
// queues the expected outputs; a monitor compares them after every clock edge.
module tb_lift_call_scheduler;
  localparam int N = 11;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lift_call_scheduler_if #(.N_FLOORS(N), .FLOOR_W(W)) bus ();
  lift_call_scheduler #(.N_FLOORS(N), .FLOOR_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [N-1:0] pend;
    logic [W-1:0] tgt;
    logic         vld;
    logic         dir;
    logic         busy;
  } obs_t;

  typedef enum {M_IDLE, M_UP, M_DOWN} mst_e;

  obs_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  mst_e   m_st;
  bit [N-1:0] m_pend;
  int     m_tgt;
  bit     m_vld, m_dir;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_pend = '0; m_tgt = 0; m_vld = 1'b0; m_dir = 1'b1;
  endfunction

  function automatic void model_go(bit up, int lo, int hi);
    m_st  = up ? M_UP : M_DOWN;
    m_dir = up;
    m_tgt = up ? lo : hi;
    m_vld = 1'b1;
  endfunction

  // Keep sweeping the preferred way (up unless already going down); else turn
  // around; else settle idle, serving a call at the car floor if there is one.
  function automatic void model_step(bit [N-1:0] call, int car, bit arr);
    int eff, lo, hi;
    bit here, pref_up;
    bit [N-1:0] clr;
    eff = (car < N) ? car : 0;
    lo = -1; hi = -1;
    here = m_pend[eff];
    for (int i = N - 1; i > eff; i--) if (m_pend[i]) lo = i;
    for (int i = 0; i < eff; i++)     if (m_pend[i]) hi = i;
    clr = '0;
    if (arr && car < N) clr[car] = 1'b1;
    pref_up = (m_st != M_DOWN);
    m_vld = 1'b0;
    if (pref_up ? (lo >= 0) : (hi >= 0))      model_go(pref_up, lo, hi);
    else if (pref_up ? (hi >= 0) : (lo >= 0)) model_go(!pref_up, lo, hi);
    else begin
      m_st = M_IDLE;
      if (here) begin m_tgt = eff; m_vld = 1'b1; end
    end
    m_pend = (m_pend | call) & ~clr;
  endfunction

  function automatic void push_exp();
    obs_t e;
    e.pend = m_pend;
    e.tgt  = W'(m_tgt);
    e.vld  = m_vld;
    e.dir  = m_dir;
    e.busy = (m_st != M_IDLE);
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input logic [N-1:0] call, input int car, input bit arr);
    @(negedge clk);
    rst           = 1'b0;
    bus.call_req  = call;
    bus.car_floor = W'(car);
    bus.arrive    = arr;
    model_step(call, car, arr);
    push_exp();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.call_req = '0;
    bus.arrive   = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pending", int'(bus.pending), 0);
    chk("async_rst_valid", int'(bus.target_valid), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_dir", int'(bus.dir_up), 1);
    model_reset();
    push_exp();
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pending", int'(bus.pending), int'(e.pend));
        chk("target_floor", int'(bus.target_floor), int'(e.tgt));
        chk("target_valid", int'(bus.target_valid), int'(e.vld));
        chk("dir_up", int'(bus.dir_up), int'(e.dir));
        chk("busy", int'(bus.busy), int'(e.busy));
      end
    end
  end

  initial begin : driver
    logic [N-1:0] call;
    int car;
    bit arr;
    bus.call_req  = '0;
    bus.car_floor = '0;
    bus.arrive    = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("reset_pending", int'(bus.pending), 0);
    chk("reset_target", int'(bus.target_floor), 0);
    chk("reset_valid", int'(bus.target_valid), 0);
    chk("reset_dir", int'(bus.dir_up), 1);
    chk("reset_busy", int'(bus.busy), 0);

    // Single call at 5 from floor 0, then serve it.
    cycle(N'(1) << 5, 0, 0);
    cycle('0, 0, 0);
    chk("a_pending5", int'(bus.pending), 32);
    cycle('0, 5, 1);
    chk("a_target5", int'(bus.target_floor), 5);
    chk("a_dir_up", int'(bus.dir_up), 1);
    chk("a_busy", int'(bus.busy), 1);
    cycle('0, 5, 0);
    cycle('0, 5, 0);
    chk("a_cleared", int'(bus.pending), 0);
    chk("a_valid_off", int'(bus.target_valid), 0);
    chk("a_idle", int'(bus.busy), 0);

    // Up sweep 4 -> 7 -> 9, then reversal down to 2.
    cycle((N'(1) << 2) | (N'(1) << 7) | (N'(1) << 9), 4, 0);
    cycle('0, 4, 0);
    cycle('0, 7, 1);
    chk("b_target7", int'(bus.target_floor), 7);
    cycle('0, 7, 0);
    chk("b_target9", int'(bus.target_floor), 9);
    cycle('0, 9, 1);
    cycle('0, 9, 0);
    chk("b_rev_dir", int'(bus.dir_up), 0);
    chk("b_rev_target2", int'(bus.target_floor), 2);
    chk("b_rev_busy", int'(bus.busy), 1);

    // Call at 6 coinciding with arrival at 6 while sweeping down is absorbed.
    cycle('0, 6, 0);
    cycle(N'(1) << 6, 6, 1);
    cycle('0, 6, 0);
    chk("c_absorbed", int'(bus.pending), 4);
    cycle('0, 2, 1);
    cycle('0, 2, 0);
    cycle('0, 2, 0);
    chk("c_valid_off", int'(bus.target_valid), 0);

    // Idle car at 3 with a call at 3.
    cycle(N'(1) << 3, 3, 0);
    cycle('0, 3, 0);
    cycle('0, 3, 0);
    chk("d_target3", int'(bus.target_floor), 3);
    chk("d_valid", int'(bus.target_valid), 1);
    chk("d_not_busy", int'(bus.busy), 0);
    cycle('0, 3, 1);
    cycle('0, 3, 0);
    cycle('0, 3, 0);
    chk("d_cleared", int'(bus.pending), 0);

    // Car floor out of range: arrive ignored, searched as floor 0.
    cycle(N'(1), 12, 0);
    cycle('0, 12, 0);
    cycle('0, 12, 1);
    cycle('0, 12, 0);
    chk("e_kept", int'(bus.pending), 1);
    chk("e_target0", int'(bus.target_floor), 0);
    chk("e_valid", int'(bus.target_valid), 1);

    // Asynchronous reset with calls pending, then 2-cycle latency after release.
    cycle(N'(1) << 10, 12, 0);
    reset_mid();
    cycle(N'(1) << 8, 0, 0);
    cycle('0, 0, 0);
    chk("f_pending8", int'(bus.pending), 256);
    cycle('0, 0, 0);
    chk("f_target8", int'(bus.target_floor), 8);
    chk("f_valid", int'(bus.target_valid), 1);

    // Random traffic with a car that chases the expected target.
    car = 0;
    for (int k = 0; k < 1500; k++) begin
      call = '0;
      arr  = 1'b0;
      if ($urandom_range(3) == 0) call[$urandom_range(N - 1)] = 1'b1;
      if ($urandom_range(40) == 0) call = N'($urandom);
      if (m_vld && (k % 2 == 0)) begin
        if (car < m_tgt) car++;
        else if (car > m_tgt) car--;
        else arr = 1'b1;
      end
      if ($urandom_range(60) == 0) car = $urandom_range(15);
      if ($urandom_range(30) == 0) arr = 1'b1;
      if (k == 700) reset_mid();
      else cycle(call, car, arr);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Latches floor calls for an 11-floor lift, keeps them pending until served, and selects the next target floor using a SCAN (elevator) policy. It sits between the call buttons and the lift state-machine controller: the controller consumes `target_floor` / `target_valid` and returns `car_floor` and an `arrive` pulse when the doors open at a floor.

## Interface
Parameters:
- `N_FLOORS`, 11: number of floors, numbered 0..N_FLOORS-1.
- `FLOOR_W`, 4: width of floor-number buses; must satisfy 2^FLOOR_W ≥ N_FLOORS.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `call_req`  in  N_FLOORS  one bit per floor; a high bit in any cycle registers a call (pulse or level).
- `car_floor`  in  FLOOR_W  current floor of the car, driven by the controller.
- `arrive`  in  1  one-cycle pulse: the car has stopped at `car_floor` and the door is opening.
- `target_floor`  out  FLOOR_W  next floor to serve; valid only when `target_valid` is high.
- `target_valid`  out  1  at least one call is pending.
- `dir_up`  out  1  sweep direction: 1 = up, 0 = down.
- `pending`  out  N_FLOORS  registered call vector.
- `busy`  out  1  scheduler state is not IDLE.

## Operation
- Pending register:
  - Each cycle, `pending[i]` is set by `call_req[i]`.
  - `pending[i]` is cleared when `arrive` is high and `car_floor == i`.
  - Clear wins over set in the same cycle, so a call at the floor being served is absorbed.
- If `car_floor ≥ N_FLOORS`, `arrive` is ignored: nothing is cleared, and the value is treated as floor 0 for the search.
- Sweep FSM states: IDLE, UP, DOWN.
  - IDLE:
    - Any pending floor above `car_floor` → UP.
    - Otherwise, any pending below → DOWN.
    - Otherwise stay in IDLE.
    - A call pending at `car_floor` while in IDLE gives `target_floor = car_floor`, `target_valid = 1` with no state change.
  - UP:
    - A pending floor above exists → target is the lowest pending floor above `car_floor`.
    - Otherwise, a pending floor below exists → DOWN.
    - Otherwise → IDLE.
  - DOWN: mirror of UP; target is the highest pending floor below `car_floor`. If none below, pending above → UP; else → IDLE.
  - In UP or DOWN, a call at `car_floor` while the car is not arrived is not targeted until the sweep reverses or the FSM goes IDLE.
- `dir_up` is set to 1 on entering UP and to 0 on entering DOWN. It holds its value in IDLE.
- `busy = (state != IDLE)`.
- All outputs are registered.
- `target_floor` holds its last value when `target_valid = 0`.
- Floor compares are unsigned, FLOOR_W bits wide.

## Timing
- Reset values:
  - `pending = 0`
  - state IDLE
  - `target_floor = 0`
  - `target_valid = 0`
  - `dir_up = 1`
  - `busy = 0`
- `call_req` high in cycle n → `pending` set at edge n+1 → `target_floor`, `target_valid`, `dir_up` and state updated at edge n+2. Latency is 2 cycles.
- `arrive` in cycle n → bit cleared at n+1 → new target or direction at n+2.
- Reversal takes one FSM transition (UP→DOWN directly). The target for the new sweep appears on the same edge as the state change.
- `rst` asserted mid-operation clears all pending calls immediately (asynchronously). The first call after release follows the same 2-cycle latency.
- `car_floor` is sampled every cycle. The controller keeps it stable while the car is stopped.

## Structure
- `lift_pkg`:
  - constants `N_FLOORS_DEF = 11`, `FLOOR_W_DEF = 4`
  - sweep state encoding `SCHED_IDLE = 0`, `SCHED_UP = 1`, `SCHED_DOWN = 2`
  - door/move state codes shared with the lift controller
- Sub-module `lift_floor_search`:
  - combinational
  - inputs: `pending`, `car_floor`
  - outputs: `any_above`, `any_below`, `any_here`, `lowest_above`, `highest_below`
  - implemented as a masked priority encode

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs at reset values; `pending = 0` immediately.
- Car at 0, pulse `call_req[5]` → `pending[5]` at +1; at +2, `target_floor = 5`, `dir_up = 1`, `busy = 1`. Set `car_floor = 5`, pulse `arrive` → `pending = 0`, FSM returns to IDLE, `target_valid = 0`.
- Car at 4 in UP with calls {2, 7, 9} → target 7; arrive at 7 → target 9; arrive at 9 → DOWN, `dir_up = 0`, target 2.
- Car at 6 in DOWN, `call_req[6]` in the same cycle as `arrive` at floor 6 → `pending[6]` stays 0.
- Car at 3 in IDLE, `call_req[3]` → at +2, `target_floor = 3`, `target_valid = 1`, `busy = 0`; `arrive` at 3 clears it.
- `car_floor = 12`, `arrive` pulsed with `pending[0]` set → `pending` unchanged, target 0.
